compressed_fetch_aligner: RTL and testbench

COMPRESSED_FETCH_ALIGNER -- requirements
Module: compressed_fetch_aligner

---
 rtl/compressed_fetch_aligner.sv | 145 ++++++++++++++
 tb/tb_compressed_fetch_aligner.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/compressed_fetch_aligner.sv
// Fetch aligner for mixed 16/32-bit instruction streams. It takes word-aligned
// imem data and issues one instruction per accepted cycle. A 16-bit half-word
// buffer covers compressed pairs and instructions that straddle a word boundary.
module compressed_fetch_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    input  logic        advance,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] fetch_pc,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    output logic        instr_compressed,
    output logic        stall_compressed
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ALIGNED         = 2'd0,
        HALF_BUF        = 2'd1,
        UNALIGNED_START = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] hbuf_q, hbuf_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] ipc_q, ipc_d;
    logic        drop_q;

    logic [31:0] c_instr;
    logic        c_issue, c_comp, c_stall;
    logic        word_ok, upd;

    // redirect_pc[0] has no meaning for a half-word aligned target
    logic unused_rpc0;
    assign unused_rpc0 = redirect_pc[0];

    // Data in the cycle after a redirect belongs to the old fetch address
    assign word_ok = imem_valid && !drop_q;
    assign upd     = advance && word_ok && !redirect;

    // Decode the current state and word into an issue candidate and next-state values
    always_comb begin
        c_instr    = NOP;
        c_issue    = 1'b0;
        c_comp     = 1'b0;
        c_stall    = 1'b0;
        state_d    = state_q;
        hbuf_d     = hbuf_q;
        fetch_pc_d = fetch_pc_q + 32'd4;
        ipc_d      = ipc_q;
        case (state_q)
            ALIGNED: begin
                if (imem_rdata[1:0] == 2'b11) begin
                    c_instr = imem_rdata;
                    c_issue = 1'b1;
                    ipc_d   = ipc_q + 32'd4;
                end else begin
                    c_instr = {16'h0, imem_rdata[15:0]};
                    c_issue = 1'b1;
                    c_comp  = 1'b1;
                    hbuf_d  = imem_rdata[31:16];
                    state_d = HALF_BUF;
                    ipc_d   = ipc_q + 32'd2;
                end
            end
            HALF_BUF: begin
                if (hbuf_q[1:0] != 2'b11) begin
                    // Buffered half is a whole instruction; the word waits a cycle
                    c_instr    = {16'h0, hbuf_q};
                    c_issue    = 1'b1;
                    c_comp     = 1'b1;
                    c_stall    = 1'b1;
                    fetch_pc_d = fetch_pc_q;
                    state_d    = ALIGNED;
                    ipc_d      = ipc_q + 32'd2;
                end else begin
                    c_instr = {imem_rdata[15:0], hbuf_q};
                    c_issue = 1'b1;
                    hbuf_d  = imem_rdata[31:16];
                    ipc_d   = ipc_q + 32'd4;
                end
            end
            UNALIGNED_START: begin
                if (imem_rdata[17:16] != 2'b11) begin
                    c_instr = {16'h0, imem_rdata[31:16]};
                    c_issue = 1'b1;
                    c_comp  = 1'b1;
                    state_d = ALIGNED;
                    ipc_d   = ipc_q + 32'd2;
                end else begin
                    // Upper half starts a 32-bit instruction; nothing to issue yet
                    hbuf_d  = imem_rdata[31:16];
                    state_d = HALF_BUF;
                end
            end
            default: begin
                state_d = ALIGNED;
            end
        endcase
    end

    // Issue outputs are qualified by reset, redirect and a usable word
    always_comb begin
        instr_valid      = reset_n && !redirect && word_ok && c_issue;
        instr            = instr_valid ? c_instr : NOP;
        instr_compressed = instr_valid && c_comp;
        stall_compressed = reset_n && !redirect && c_stall;
    end

    // Register update: reset, then redirect, then accepted-cycle advance
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ALIGNED;
            hbuf_q     <= 16'h0;
            fetch_pc_q <= RESET_PC & ~32'h3;
            ipc_q      <= RESET_PC & ~32'h1;
            drop_q     <= 1'b1;
        end else if (redirect) begin
            state_q    <= redirect_pc[1] ? UNALIGNED_START : ALIGNED;
            hbuf_q     <= 16'h0;
            fetch_pc_q <= {redirect_pc[31:2], 2'b00};
            ipc_q      <= {redirect_pc[31:1], 1'b0};
            drop_q     <= 1'b1;
        end else begin
            drop_q <= 1'b0;
            if (upd) begin
                state_q    <= state_d;
                hbuf_q     <= hbuf_d;
                fetch_pc_q <= fetch_pc_d;
                ipc_q      <= ipc_d;
            end
        end
    end

    assign fetch_pc = fetch_pc_q;
    assign instr_pc = ipc_q;

endmodule

// File: tb/tb_compressed_fetch_aligner.sv
// Scoreboard bench for compressed_fetch_aligner: directed words with
// hand-derived issues queued as expectations, popped by a negedge monitor.
module tb_compressed_fetch_aligner;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic        advance;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] fetch_pc;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_compressed;
    logic        stall_compressed;

    compressed_fetch_aligner #(.RESET_PC(RESET_PC)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .imem_rdata       (imem_rdata),
        .imem_valid       (imem_valid),
        .advance          (advance),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .fetch_pc         (fetch_pc),
        .instr            (instr),
        .instr_pc         (instr_pc),
        .instr_valid      (instr_valid),
        .instr_compressed (instr_compressed),
        .stall_compressed (stall_compressed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        comp;
        logic        stall;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    bit          pk_en = 1'b0;
    logic        pk_vld;
    logic [31:0] pk_instr;
    logic        pk_stall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] i, input logic [31:0] pc, input logic c, input logic s);
        exp_t e;
        e.instr = i;
        e.pc    = pc;
        e.comp  = c;
        e.stall = s;
        sb.push_back(e);
    endtask

    task automatic peek(input logic v, input logic [31:0] i, input logic s);
        pk_en    = 1'b1;
        pk_vld   = v;
        pk_instr = i;
        pk_stall = s;
    endtask

    // One clock: apply inputs, optionally inspect combinational outputs mid-cycle
    task automatic cyc(input logic rn, input logic adv, input logic vld,
                       input logic [31:0] w, input logic rd, input logic [31:0] rpc);
        reset_n     = rn;
        advance     = adv;
        imem_valid  = vld;
        imem_rdata  = w;
        redirect    = rd;
        redirect_pc = rpc;
        @(negedge clk);
        if (pk_en) begin
            chk("peek_valid", {31'h0, instr_valid}, {31'h0, pk_vld});
            chk("peek_instr", instr, pk_instr);
            chk("peek_stall", {31'h0, stall_compressed}, {31'h0, pk_stall});
            pk_en = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic regs(input logic [31:0] fpc, input logic [31:0] ipc);
        chk("fetch_pc", fetch_pc, fpc);
        chk("instr_pc", instr_pc, ipc);
    endtask

    // Monitor: every accepted issue must match the head of the scoreboard
    always @(negedge clk) begin
        if (instr_valid && advance) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL issue_unexpected: got instr %h pc %h, required no issue", instr, instr_pc);
            end else begin
                mon_e = sb.pop_front();
                chk("issue_instr", instr, mon_e.instr);
                chk("issue_pc", instr_pc, mon_e.pc);
                chk("issue_comp", {31'h0, instr_compressed}, {31'h0, mon_e.comp});
                chk("issue_stall", {31'h0, stall_compressed}, {31'h0, mon_e.stall});
            end
        end
        if (!instr_valid) begin
            chk("idle_nop", instr, NOP);
            chk("idle_comp", {31'h0, instr_compressed}, 32'h0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; advance = 1'b0; imem_valid = 1'b0;
        imem_rdata = 32'h0; redirect = 1'b0; redirect_pc = 32'h0;

        // Reset
        peek(1'b0, NOP, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        peek(1'b0, NOP, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 32'h0050_0093, 1'b0, 32'h0);
        regs(RESET_PC, RESET_PC);
        // First cycle after reset: word dropped
        peek(1'b0, NOP, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 32'h0050_0093, 1'b0, 32'h0);
        regs(32'h0, 32'h0);

        // 32-bit stream
        push(32'h0050_0093, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 32'h0050_0093, 1'b0, 32'h0);
        regs(32'h4, 32'h4);
        push(32'h00A0_0113, 32'h4, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 32'h00A0_0113, 1'b0, 32'h0);
        regs(32'h8, 32'h8);

        // Two compressed in one word
        push(32'h0000_4485, 32'h8, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 32'h4501_4485, 1'b0, 32'h0);
        regs(32'hC, 32'hA);
        push(32'h0000_4501, 32'hA, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 32'h0093_4485, 1'b0, 32'h0);
        regs(32'hC, 32'hC);

        // Straddling 32-bit instruction
        push(32'h0000_4485, 32'hC, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 32'h0093_4485, 1'b0, 32'h0);
        regs(32'h10, 32'hE);
        push(32'h0093_0093, 32'hE, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 32'h1234_0093, 1'b0, 32'h0);
        regs(32'h14, 32'h12);

        // Hold in HALF_BUF (hbuf=1234 shows as a pending compressed issue)
        for (int i = 0; i < 3; i++) begin
            peek(1'b1, 32'h0000_1234, 1'b1);
            cyc(1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0);
            regs(32'h14, 32'h12);
        end

        // Redirect with advance=0, even target
        peek(1'b0, NOP, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 32'h0, 1'b1, 32'h200);
        regs(32'h200, 32'h200);
        peek(1'b0, NOP, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 32'h0000_4485, 1'b0, 32'h0);
        regs(32'h200, 32'h200);
        push(32'h00A0_0113, 32'h200, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 32'h00A0_0113, 1'b0, 32'h0);
        regs(32'h204, 32'h204);

        // Redirect to 0x106 (bit 0 set, ignored): upper compressed half issues
        peek(1'b0, NOP, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 32'h0050_0093, 1'b1, 32'h107);
        regs(32'h104, 32'h106);
        peek(1'b0, NOP, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 32'h4485_0093, 1'b0, 32'h0);
        regs(32'h104, 32'h106);
        push(32'h0000_4485, 32'h106, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 32'h4485_0013, 1'b0, 32'h0);
        regs(32'h108, 32'h108);

        // Redirect to 0x106: upper half starts a 32-bit instruction
        cyc(1'b1, 1'b1, 1'b1, 32'h0, 1'b1, 32'h106);
        regs(32'h104, 32'h106);
        cyc(1'b1, 1'b1, 1'b1, 32'h4485_0013, 1'b0, 32'h0);
        regs(32'h104, 32'h106);
        peek(1'b0, NOP, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 32'h0093_0013, 1'b0, 32'h0);
        regs(32'h108, 32'h106);
        push(32'h0513_0093, 32'h106, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 32'h4501_0513, 1'b0, 32'h0);
        regs(32'h10C, 32'h10A);
        push(32'h0000_4501, 32'h10A, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 32'h4501_4485, 1'b0, 32'h0);
        regs(32'h10C, 32'h10C);

        // imem_valid low: nothing moves
        peek(1'b0, NOP, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 32'h4501_4485, 1'b0, 32'h0);
        regs(32'h10C, 32'h10C);
        push(32'h0000_4485, 32'h10C, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 32'h4501_4485, 1'b0, 32'h0);
        regs(32'h110, 32'h10E);

        // Reset while in HALF_BUF discards the buffered half
        peek(1'b0, NOP, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 32'h4501_4485, 1'b0, 32'h0);
        regs(RESET_PC, RESET_PC);
        peek(1'b0, NOP, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 32'h0050_0093, 1'b0, 32'h0);
        regs(RESET_PC, RESET_PC);
        push(32'h0050_0093, RESET_PC, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 32'h0050_0093, 1'b0, 32'h0);
        regs(RESET_PC + 32'h4, RESET_PC + 32'h4);

        // Address wrap at the top of the space
        cyc(1'b1, 1'b1, 1'b1, 32'h0, 1'b1, 32'hFFFF_FFFE);
        regs(32'hFFFF_FFFC, 32'hFFFF_FFFE);
        cyc(1'b1, 1'b1, 1'b1, 32'h4485_0000, 1'b0, 32'h0);
        regs(32'hFFFF_FFFC, 32'hFFFF_FFFE);
        push(32'h0000_4485, 32'hFFFF_FFFE, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 32'h4485_0000, 1'b0, 32'h0);
        regs(32'h0, 32'h0);

        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("sb_leftover", sb.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
